// File: rtl/mem_router_if.sv
// Decoupled request/response channels between a memory master and its slaves.
// The master modport drives valid and payload; the slave modport drives ready.
interface mem_req_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;

  modport master (output valid, addr, wdata, we, input ready);
  modport slave  (input valid, addr, wdata, we, output ready);
endinterface

interface mem_resp_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output valid, rdata, input ready);
  modport slave  (input valid, rdata, output ready);
endinterface

// File: rtl/mem_router.sv
// Address-decoded fan-out of one memory master to CNT slaves, with responses
// returned in request order via a FIFO of slave indices.
module mem_router #(
  parameter int CNT         = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [CNT-1:0][ADDR_WIDTH-1:0] BASE = {32'h8000_0000, 32'h0000_0000},
  parameter logic [CNT-1:0][ADDR_WIDTH-1:0] MASK = {32'h8000_0000, 32'h8000_0000},
  parameter int DEFAULT_IDX = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_req_if.slave                     master_req,
  mem_resp_if.master                   master_resp,
  mem_req_if.master                    slave_req [CNT],
  mem_resp_if.slave                    slave_resp [CNT],
  output logic [$clog2(QUEUE_DEPTH):0] outstanding
);

  localparam int IW = $clog2(CNT);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  if (CNT < 2) begin : g_bad_cnt
    $error("mem_router: CNT must be at least 2");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_router: QUEUE_DEPTH must be a power of two, at least 2");
  end

  logic [IW-1:0]         sel;
  logic [IW-1:0]         head;
  logic [IW-1:0]         fifo_q [QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic                  push, pop;
  logic [CNT-1:0]        s_req_ready;
  logic [CNT-1:0]        s_resp_valid;
  logic [DATA_WIDTH-1:0] s_resp_rdata [CNT];

  // Reverse scan so the lowest matching index overrides higher ones.
  always_comb begin
    sel = IW'(DEFAULT_IDX);
    for (int i = CNT - 1; i >= 0; i--) begin
      if ((master_req.addr & MASK[i]) == BASE[i]) sel = IW'(i);
    end
  end

  assign full  = (count == CW'(QUEUE_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo_q[rd_ptr];

  // Every output is gated by rst so reset quiets the bus without a clock.
  assign master_req.ready  = rst && !full && s_req_ready[sel];
  assign master_resp.valid = rst && !empty && s_resp_valid[head];
  assign master_resp.rdata = s_resp_rdata[head];

  assign push = master_req.valid && master_req.ready;
  assign pop  = master_resp.valid && master_resp.ready;

  for (genvar g = 0; g < CNT; g++) begin : g_port
    assign s_req_ready[g]     = slave_req[g].ready;
    assign slave_req[g].valid = rst && master_req.valid && !full && (sel == IW'(g));
    assign slave_req[g].addr  = master_req.addr;
    assign slave_req[g].wdata = master_req.wdata;
    assign slave_req[g].we    = master_req.we;

    assign s_resp_valid[g]    = slave_resp[g].valid;
    assign s_resp_rdata[g]    = slave_resp[g].rdata;
    assign slave_resp[g].ready = rst && !empty && master_resp.ready && (head == IW'(g));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= sel;
  end

  assign outstanding = count;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: decode, in-order return, full/backpressure
// behaviour and the fallback slave for unmapped addresses.
module tb_mem_router;

  logic        clk, rst;
  logic        m_valid, m_we, mr_ready;
  logic [31:0] m_addr, m_wdata;
  logic        sq_ready [2];
  logic        sr_valid [2];
  logic [31:0] sr_rdata [2];
  logic        m_ready, mr_valid;
  logic [31:0] mr_rdata;
  logic        sq_valid [2];
  logic [31:0] sq_addr  [2];
  logic        sr_ready [2];
  logic [2:0]  outstanding;

  logic        u_valid;
  logic [31:0] u_addr;
  logic        u_sq_valid [2];
  logic [2:0]  u_outstanding;

  int checks = 0;
  int errors = 0;

  mem_req_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_req ();
  mem_resp_if #(.DATA_WIDTH(32))                  m_resp ();
  mem_req_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_req [2] ();
  mem_resp_if #(.DATA_WIDTH(32))                  s_resp [2] ();

  mem_req_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_m_req ();
  mem_resp_if #(.DATA_WIDTH(32))                  u_m_resp ();
  mem_req_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_s_req [2] ();
  mem_resp_if #(.DATA_WIDTH(32))                  u_s_resp [2] ();

  assign m_req.valid   = m_valid;
  assign m_req.addr    = m_addr;
  assign m_req.wdata   = m_wdata;
  assign m_req.we      = m_we;
  assign m_ready       = m_req.ready;
  assign m_resp.ready  = mr_ready;
  assign mr_valid      = m_resp.valid;
  assign mr_rdata      = m_resp.rdata;

  assign u_m_req.valid  = u_valid;
  assign u_m_req.addr   = u_addr;
  assign u_m_req.wdata  = 32'h0;
  assign u_m_req.we     = 1'b0;
  assign u_m_resp.ready = 1'b1;

  for (genvar g = 0; g < 2; g++) begin : g_tb
    assign s_req[g].ready   = sq_ready[g];
    assign sq_valid[g]      = s_req[g].valid;
    assign sq_addr[g]       = s_req[g].addr;
    assign s_resp[g].valid  = sr_valid[g];
    assign s_resp[g].rdata  = sr_rdata[g];
    assign sr_ready[g]      = s_resp[g].ready;

    assign u_s_req[g].ready  = 1'b1;
    assign u_sq_valid[g]     = u_s_req[g].valid;
    assign u_s_resp[g].valid = 1'b0;
    assign u_s_resp[g].rdata = 32'h0;
  end

  mem_router dut (
    .clk         (clk),
    .rst         (rst),
    .master_req  (m_req),
    .master_resp (m_resp),
    .slave_req   (s_req),
    .slave_resp  (s_resp),
    .outstanding (outstanding)
  );

  mem_router #(
    .BASE ({32'h9000_0000, 32'h0000_0000}),
    .MASK ({32'hF000_0000, 32'h8000_0000})
  ) dut_unmapped (
    .clk         (clk),
    .rst         (rst),
    .master_req  (u_m_req),
    .master_resp (u_m_resp),
    .slave_req   (u_s_req),
    .slave_resp  (u_s_resp),
    .outstanding (u_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h8000_0010;
    sq_ready[0] = 1'b1; sq_ready[1] = 1'b1;
    sr_valid[1] = 1'b1; mr_ready = 1'b1;
    #1;
    checks++; if (sq_valid[1] !== 1'b0) begin errors++; $display("FAIL rst_sq_valid got %b exp 0", sq_valid[1]); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_m_ready got %b exp 0", m_ready); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    checks++; if (sr_ready[1] !== 1'b0 || mr_valid !== 1'b0) begin errors++; $display("FAIL rst_resp got ready %b valid %b exp 0 0", sr_ready[1], mr_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (sq_valid[1] !== 1'b1 || sq_valid[0] !== 1'b0) begin errors++; $display("FAIL rel_sq_valid got %b%b exp 10", sq_valid[1], sq_valid[0]); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rel_m_ready got %b exp 1", m_ready); end
    checks++; if (sr_ready[1] !== 1'b0) begin errors++; $display("FAIL rel_late_resp_ready got %b exp 0", sr_ready[1]); end
    m_valid = 1'b0; sr_valid[1] = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_1000;
    addrs[1] = 32'h8000_1000;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      m_valid = 1'b1; m_addr = addrs[s];
      #1;
      checks++; if (sq_valid[s] !== 1'b1 || sq_valid[1-s] !== 1'b0) begin errors++; $display("FAIL dec_route%0d got %b%b", s, sq_valid[1], sq_valid[0]); end
      checks++; if (sq_addr[s] !== addrs[s]) begin errors++; $display("FAIL dec_addr%0d got %h exp %h", s, sq_addr[s], addrs[s]); end
      @(negedge clk);
      m_valid = 1'b0;
      sr_valid[s] = 1'b1; sr_rdata[s] = 32'hCAFE_0000 + 32'(s);
      #1;
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL dec_out1_%0d got %0d exp 1", s, outstanding); end
      checks++; if (mr_valid !== 1'b1 || mr_rdata !== 32'hCAFE_0000 + 32'(s)) begin errors++; $display("FAIL dec_resp%0d got %b %h", s, mr_valid, mr_rdata); end
      @(negedge clk);
      sr_valid[s] = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL dec_out0_%0d got %0d exp 0", s, outstanding); end
    end
  endtask

  task automatic test_ordering();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h8000_0020;
    @(negedge clk);
    m_addr = 32'h0000_0040;
    @(negedge clk);
    m_valid = 1'b0;
    sr_valid[0] = 1'b1; sr_rdata[0] = 32'hBBBB_BBBB;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (sr_ready[0] !== 1'b0 || mr_valid !== 1'b0) begin errors++; $display("FAIL ord_hold%0d got ready %b valid %b exp 0 0", c, sr_ready[0], mr_valid); end
      checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL ord_out%0d got %0d exp 2", c, outstanding); end
    end
    @(negedge clk);
    sr_valid[1] = 1'b1; sr_rdata[1] = 32'hAAAA_AAAA;
    #1;
    checks++; if (mr_valid !== 1'b1 || mr_rdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL ord_first got %b %h exp 1 aaaaaaaa", mr_valid, mr_rdata); end
    checks++; if (sr_ready[1] !== 1'b1 || sr_ready[0] !== 1'b0) begin errors++; $display("FAIL ord_ready got %b%b exp 10", sr_ready[1], sr_ready[0]); end
    @(negedge clk);
    sr_valid[1] = 1'b0;
    #1;
    checks++; if (mr_valid !== 1'b1 || mr_rdata !== 32'hBBBB_BBBB || sr_ready[0] !== 1'b1) begin errors++; $display("FAIL ord_second got %b %h %b", mr_valid, mr_rdata, sr_ready[0]); end
    @(negedge clk);
    sr_valid[0] = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ord_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_full();
    int order [4];
    order[0] = 1; order[1] = 0; order[2] = 1; order[3] = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_valid = 1'b1;
      m_addr  = (i % 2 == 1) ? (32'h8000_0000 | 32'(i << 4)) : 32'(i << 4);
      #1;
      checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL full_acc%0d got %b exp 1", i, m_ready); end
    end
    @(negedge clk);
    m_addr = 32'h0000_0500;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out got %0d exp 4", outstanding); end
    checks++; if (m_ready !== 1'b0 || sq_valid[0] !== 1'b0) begin errors++; $display("FAIL full_block got ready %b valid %b exp 0 0", m_ready, sq_valid[0]); end
    sr_valid[0] = 1'b1; sr_rdata[0] = 32'h0000_0100;
    #1;
    checks++; if (m_ready !== 1'b0 || mr_valid !== 1'b1) begin errors++; $display("FAIL full_nopass got ready %b resp %b exp 0 1", m_ready, mr_valid); end
    @(negedge clk);
    sr_valid[0] = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3 || m_ready !== 1'b1) begin errors++; $display("FAIL full_pop got out %0d ready %b exp 3 1", outstanding, m_ready); end
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_fifth got %0d exp 4", outstanding); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      sr_valid[0] = 1'b0; sr_valid[1] = 1'b0;
      sr_valid[order[k]] = 1'b1; sr_rdata[order[k]] = 32'h0000_0200 + 32'(k);
      #1;
      checks++; if (mr_valid !== 1'b1 || mr_rdata !== 32'h0000_0200 + 32'(k)) begin errors++; $display("FAIL full_drain%0d got %b %h", k, mr_valid, mr_rdata); end
    end
    @(negedge clk);
    sr_valid[0] = 1'b0; sr_valid[1] = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    int          q_s [$];
    logic [31:0] q_d [$];
    int          h;
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h8000_0100;
    q_s.push_back(1); q_d.push_back(32'hD000_0001);
    @(negedge clk);
    m_addr = 32'h0000_0200;
    q_s.push_back(0); q_d.push_back(32'hD000_0002);
    @(negedge clk);
    m_valid = 1'b0; mr_ready = 1'b0;
    sr_valid[1] = 1'b1; sr_rdata[1] = q_d[0];
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (mr_valid !== 1'b1 || mr_rdata !== q_d[0] || sr_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %b %h %b", c, mr_valid, mr_rdata, sr_ready[1]); end
      checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL bp_out%0d got %0d exp 2", c, outstanding); end
    end
    @(negedge clk);
    mr_ready = 1'b1; m_valid = 1'b1; m_addr = 32'h0000_0300;
    #1;
    checks++; if (m_ready !== 1'b1 || sr_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_pushpop got %b %b exp 1 1", m_ready, sr_ready[1]); end
    void'(q_s.pop_front()); void'(q_d.pop_front());
    q_s.push_back(0); q_d.push_back(32'hD000_0003);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      h = q_s[0];
      sr_valid[0] = 1'b0; sr_valid[1] = 1'b0;
      sr_valid[h] = 1'b1; sr_rdata[h] = q_d[0];
      m_addr = (k % 2 == 1) ? (32'h8000_0000 | 32'(k << 8)) : 32'(k << 8);
      #1;
      checks++; if (mr_valid !== 1'b1 || mr_rdata !== q_d[0]) begin errors++; $display("FAIL b2b_resp%0d got %b %h exp %h", k, mr_valid, mr_rdata, q_d[0]); end
      checks++; if (outstanding !== 3'd2 || m_ready !== 1'b1) begin errors++; $display("FAIL b2b_out%0d got %0d %b exp 2 1", k, outstanding, m_ready); end
      void'(q_s.pop_front()); void'(q_d.pop_front());
      q_s.push_back(k % 2); q_d.push_back(32'hE000_0000 + 32'(k));
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      m_valid = 1'b0;
      h = q_s[0];
      sr_valid[0] = 1'b0; sr_valid[1] = 1'b0;
      sr_valid[h] = 1'b1; sr_rdata[h] = q_d[0];
      #1;
      checks++; if (mr_valid !== 1'b1 || mr_rdata !== q_d[0]) begin errors++; $display("FAIL b2b_drain%0d got %b %h exp %h", j, mr_valid, mr_rdata, q_d[0]); end
      void'(q_s.pop_front()); void'(q_d.pop_front());
    end
    @(negedge clk);
    sr_valid[0] = 1'b0; sr_valid[1] = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", outstanding); end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [4];
    int          exp_s [4];
    addrs[0] = 32'hA000_0000; exp_s[0] = 0;
    addrs[1] = 32'h9000_1234; exp_s[1] = 1;
    addrs[2] = 32'h1234_0000; exp_s[2] = 0;
    addrs[3] = 32'h8000_0000; exp_s[3] = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_valid = 1'b1; u_addr = addrs[i];
      #1;
      checks++; if (u_sq_valid[exp_s[i]] !== 1'b1 || u_sq_valid[1-exp_s[i]] !== 1'b0) begin errors++; $display("FAIL unmap%0d got %b%b exp slave %0d", i, u_sq_valid[1], u_sq_valid[0], exp_s[i]); end
      #1 u_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = 32'h1234_5678;
    mr_ready = 1'b0;
    u_valid = 1'b0; u_addr = '0;
    for (int i = 0; i < 2; i++) begin
      sq_ready[i] = 1'b1; sr_valid[i] = 1'b0; sr_rdata[i] = '0;
    end
    #2 rst = 1'b0;
    test_reset();
    test_decode();
    test_ordering();
    test_full();
    test_back_to_back();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
